mult_div_unit: RTL and testbench

Iterative multiply/divide unit that sits directly downstream of the 32x32 register file. It consumes read_data_1/read_data_2 as operands and holds the MIPS HI/LO result registers. It executes MULT, MULTU, DIV and DIVU over multiple cycles using a start/busy/done handshake, and supports direct HI/LO writes (MTHI/MTLO). HI/LO are readable at all times for MFHI/MFLO writeback.

---
 rtl/mult_div_pkg.sv | 23 ++
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_abs.sv | 13 +
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the divide-by-zero LO pattern.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  // Wide enough for any supported WIDTH; users slice the low bits.
  localparam logic [63:0] DIV0_LO = '1;

  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the register-file stage and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo, wdata,
    output hi, lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/mult_div_abs.sv
// Conditional two's-complement negate, used for operand magnitudes on entry
// and for sign correction of results.
module mult_div_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_value,
  input  logic         i_negate,
  output logic [W-1:0] o_value
);

  assign o_value = i_negate ? -i_value : i_value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO, with MTHI/MTLO writes.
// Optional MULT_DIV_EARLY_OUT_EN ends multiplies once the multiplier runs out of ones.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             r_state;
  logic               r_isDiv;
  logic               r_negLo;
  logic               r_negHi;
  logic               r_div0;
  logic               r_done;
  logic               r_dz;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rawA;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;

  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_mulAcc;
  logic [WIDTH:0]     w_remShift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_remNext;
  logic [2*WIDTH-1:0] w_divAcc;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;
  logic               w_lastIter;

  assign w_signA = isSignedOp(bus.op) & bus.operand_a[WIDTH-1];
  assign w_signB = isSignedOp(bus.op) & bus.operand_b[WIDTH-1];

  mult_div_abs #(.W(WIDTH)) uAbsA (.i_value(bus.operand_a), .i_negate(w_signA), .o_value(w_absA));
  mult_div_abs #(.W(WIDTH)) uAbsB (.i_value(bus.operand_b), .i_negate(w_signB), .o_value(w_absB));

  // Multiply: multiplicand shifts left, multiplier shifts right, so the
  // accumulator is already aligned whenever the run stops.
  assign w_mulAcc = r_acc + (r_b[0] ? r_mcand : '0);

  // Restoring divide: r_acc holds {remainder, dividend/quotient}.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = w_remShift >= {1'b0, r_b};
  assign w_remNext  = w_ge ? (w_remShift[WIDTH-1:0] - r_b) : w_remShift[WIDTH-1:0];
  assign w_divAcc   = {w_remNext, r_acc[WIDTH-2:0], w_ge};

  mult_div_abs #(.W(2*WIDTH)) uFixProd (.i_value(r_acc), .i_negate(r_negLo), .o_value(w_prodFix));
  mult_div_abs #(.W(WIDTH)) uFixQuo (.i_value(r_acc[WIDTH-1:0]), .i_negate(r_negLo), .o_value(w_quoFix));
  mult_div_abs #(.W(WIDTH)) uFixRem (.i_value(r_acc[2*WIDTH-1:WIDTH]), .i_negate(r_negHi), .o_value(w_remFix));

`ifdef MULT_DIV_EARLY_OUT_EN
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1)) | (~r_isDiv & (r_b[WIDTH-1:1] == '0));
`else
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_isDiv <= 1'b0;
      r_negLo <= 1'b0;
      r_negHi <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_b     <= '0;
      r_rawA  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_isDiv <= bus.op[1];
            r_negLo <= w_signA ^ w_signB;
            r_negHi <= w_signA;
            r_div0  <= bus.op[1] & (bus.operand_b == '0);
            r_rawA  <= bus.operand_a;
            r_b     <= w_absB;
            r_mcand <= {{WIDTH{1'b0}}, w_absA};
            r_acc   <= bus.op[1] ? {{WIDTH{1'b0}}, w_absA} : '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_isDiv) begin
            r_acc <= w_divAcc;
          end else begin
            r_acc   <= w_mulAcc;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end
          if (w_lastIter) r_state <= FINISH;
        end
        FINISH: begin
          if (r_div0) begin
            r_hi <= r_rawA;
            r_lo <= DIV0_LO[WIDTH-1:0];
          end else if (r_isDiv) begin
            r_hi <= w_remFix;
            r_lo <= w_quoFix;
          end else begin
            {r_hi, r_lo} <= w_prodFix;
          end
          r_done  <= 1'b1;
          r_dz    <= r_div0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: vector table plus
// hand-written sequences for busy-time inputs, HI/LO writes and mid-run reset.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int WIDTH    = 32;
  localparam int LAT      = WIDTH + 1;
  localparam int MAX_WAIT = 60;
  localparam int NVEC     = 13;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NVEC];

  mult_div_unit_if #(.WIDTH(WIDTH)) bus();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called #1 after a rising edge; holds start for exactly one edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int edges, output logic seen);
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    int   edges;
    logic seen;
    int   doneCnt;
    int   busyCnt;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'h0000000F, 32'h00000000, 32'h0000000F, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{OP_MULT,  32'h00000000, 32'h00000007, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.op        = OP_MULT;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.wdata     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_dz", bus.div_by_zero, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].op, vecs[v].a, vecs[v].b);
      waitDone(edges, seen);
`ifdef MULT_DIV_EARLY_OUT_EN
      if (!vecs[v].op[1])
        checkOutput($sformatf("vec%0d_latency_range", v), (seen && edges >= 2 && edges <= LAT), 1);
      else
        checkOutput($sformatf("vec%0d_latency", v), edges, LAT);
`else
      checkOutput($sformatf("vec%0d_latency", v), edges, LAT);
`endif
      checkOutput($sformatf("vec%0d_hi", v), bus.hi, vecs[v].expHi);
      checkOutput($sformatf("vec%0d_lo", v), bus.lo, vecs[v].expLo);
      checkOutput($sformatf("vec%0d_dz", v), bus.div_by_zero, vecs[v].expDz);
      checkOutput($sformatf("vec%0d_busy_at_done", v), bus.busy, 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_one_cycle", v), bus.done, 0);
    end

    // A second start and an mthi while busy must both be ignored.
    applyStimulus(OP_MULTU, 32'd2, 32'd3);
    seen = 1'b0;
    for (int i = 1; i <= MAX_WAIT && !seen; i++) begin
      if (i == 5 && bus.busy) begin
        bus.start     = 1'b1;
        bus.op        = OP_DIVU;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
      end
      if (i == 10 && bus.busy) begin
        bus.mthi  = 1'b1;
        bus.wdata = 32'hAAAA5555;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    checkOutput("busy_ops_done_seen", seen, 1);
    checkOutput("busy_ops_hi", bus.hi, 32'h0);
    checkOutput("busy_ops_lo", bus.lo, 32'h6);
    doneCnt = 0;
    busyCnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCnt++;
      if (bus.busy) busyCnt++;
    end
    checkOutput("stray_start_no_done", doneCnt, 0);
    checkOutput("stray_start_no_busy", busyCnt, 0);

    bus.mtlo  = 1'b1;
    bus.wdata = 32'h00001234;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    checkOutput("mtlo_lo", bus.lo, 32'h00001234);
    checkOutput("mtlo_hi_untouched", bus.hi, 32'h0);

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    checkOutput("mthi_mtlo_hi", bus.hi, 32'hCAFEF00D);
    checkOutput("mthi_mtlo_lo", bus.lo, 32'hCAFEF00D);

    // start and mthi in the same cycle: start wins.
    bus.mthi  = 1'b1;
    bus.wdata = 32'hDEAD0000;
    applyStimulus(OP_MULTU, 32'd1, 32'd1);
    bus.mthi = 1'b0;
    checkOutput("start_wins_busy", bus.busy, 1);
    checkOutput("start_wins_hi_held", bus.hi, 32'hCAFEF00D);
    waitDone(edges, seen);
    checkOutput("start_wins_done_seen", seen, 1);
    checkOutput("start_wins_hi", bus.hi, 32'h0);
    checkOutput("start_wins_lo", bus.lo, 32'h1);

    // Reset mid-divide discards the operation entirely.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    doneCnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) reset = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done) doneCnt++;
      if (i == 9) begin
        checkOutput("run_busy", bus.busy, 1);
        checkOutput("run_lo_held", bus.lo, 32'h1);
      end
    end
    reset = 1'b1;
    checkOutput("midrun_reset_hi", bus.hi, 0);
    checkOutput("midrun_reset_lo", bus.lo, 0);
    checkOutput("midrun_reset_busy", bus.busy, 0);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCnt++;
    end
    checkOutput("midrun_reset_no_done", doneCnt, 0);

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitDone(edges, seen);
    checkOutput("after_reset_latency", edges, LAT);
    checkOutput("after_reset_hi", bus.hi, 32'h2);
    checkOutput("after_reset_lo", bus.lo, 32'hE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
